mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Sequences the single-ported unified instruction/data memory of the 5-stage RV32I pipeline between the IF-stage fetch requester and the MEM-stage load/store requester.
- Serves both requesters in a fixed-order "slot": data first, then fetch. It holds the pipeline stalled until every request latched at slot start has completed.
- Supports variable-latency memory through a ready handshake, with a wait-state timeout that flags an error.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- MAX_WAIT, 15, max cycles a memory access may wait for mem_ready before abort (must be >=1)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request (level, held while pipe_stall=1)
- if_addr  input  ADDR_W  fetch address (PC)
- if_rdata  output  DATA_W  fetched instruction, registered
- if_valid  output  1  one-cycle pulse: if_rdata valid
- dm_req  input  1  data access request (level)
- dm_we  input  1  1=store, 0=load
- dm_be  input  4  byte enables for store
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data, registered
- dm_valid  output  1  one-cycle pulse: data access complete
- mem_req  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_be  output  4  memory byte enables (4'b0000 on reads)
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  input  1  access completes this cycle (sampled only while mem_req=1)
- pipe_stall  output  1  hold all pipeline registers
- mem_err  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. Reset forces the FSM to IDLE; clears the pending flags, latched request fields and wait counter; and drives if_rdata, dm_rdata, if_valid, dm_valid, mem_req, mem_we, mem_be, mem_addr, mem_wdata and mem_err to 0. pipe_stall is combinational and reads 0 while reset is held.
- FSM states: IDLE, DATA, FETCH, DONE.
- IDLE: mem_req=0. pipe_stall = if_req | dm_req.
  - On any request: latch pend_d=dm_req, pend_f=if_req, and all request fields (addr/we/be/wdata).
  - Next state is DATA if dm_req, else FETCH.
- DATA: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata come from the latched data request. pipe_stall=1.
  - On mem_ready: if the access is a load, dm_rdata <= mem_rdata. Then go to FETCH if pend_f, else DONE.
- FETCH: mem_req=1, mem_we=0, mem_be=0, mem_addr = latched if_addr. pipe_stall=1.
  - On mem_ready: if_rdata <= mem_rdata, then go to DONE.
- DONE: mem_req=0, pipe_stall=0 (pipeline advances this cycle).
  - if_valid=pend_f and dm_valid=pend_d for exactly this cycle.
  - Clear the pending flags, then go to IDLE.
- Priority: within a slot, data is always served before fetch because the MEM-stage instruction is older. Requests that arrive mid-slot are ignored until the next IDLE.
- Wait counter:
  - Resets to 0 on entry to DATA or FETCH and increments on each cycle with mem_ready=0.
  - If the counter reaches MAX_WAIT with mem_ready still 0: pulse mem_err for 1 cycle, leave the rdata register unchanged, and advance exactly as if ready had been seen. The slot still completes and the corresponding valid still pulses in DONE.
- Latency with zero-wait memory (mem_ready=1 while mem_req=1), counted from the IDLE cycle where the request is seen to the valid pulse:
  - fetch only: 2 cycles
  - data only: 2 cycles
  - data+fetch: 3 cycles
- Each wait state adds 1 cycle.
- mem_req never asserts in IDLE or DONE. mem_we is asserted only in DATA with a latched store.
- Asynchronous reset mid-access drops mem_req immediately and clears both valid pulses; the interrupted access produces no valid and no mem_err.
- The outputs dm_rdata and if_rdata hold their last value until overwritten.

Test Plan:
- Reset: assert rst for 2 cycles with requests active -> all outputs 0, mem_req=0; after release with no requests, FSM idles with pipe_stall=0.
- Fetch only, mem_ready=1: if_req=1, if_addr=0x100, mem_rdata=0x00500093 -> mem_addr=0x100 in cycle 2, if_valid pulse in cycle 3 with if_rdata=0x00500093, pipe_stall=1 in cycles 1-2 and 0 in cycle 3.
- Load + fetch together: dm_addr=0x2000 (mem_rdata 0xDEADBEEF), if_addr=0x104 (mem_rdata 0x00000013) -> mem_addr=0x2000 then 0x104. dm_valid and if_valid pulse in the same DONE cycle with dm_rdata=0xDEADBEEF and if_rdata=0x00000013.
- Store with 2 wait states: dm_we=1, dm_be=4'b0011, dm_wdata=0x1234, mem_ready low 2 cycles -> mem_we=1 and mem_be=4'b0011 held stable 3 cycles, dm_valid 1 cycle after ready, dm_rdata unchanged.
- Timeout, MAX_WAIT=4, mem_ready=0 forever on a fetch -> mem_err pulses after the 4th wait cycle, if_valid pulses in the next cycle, if_rdata unchanged, FSM returns to IDLE.
- Reset mid-DATA: assert rst on the 2nd wait cycle of a load -> mem_req drops asynchronously, no dm_valid or mem_err pulse, and the next request after release completes normally.

Source files
------------

// File: rtl/mem_port_sequencer_if.sv
// Bus bundle between the unified-memory sequencer, the IF/MEM stage
// requesters and the memory itself. The master view is the sequencer.
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    // Load/store requester
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Pipeline control and status
    logic              pipe_stall;
    logic              mem_err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_valid,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output pipe_stall, mem_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  pipe_stall, mem_err
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// Arbitrates the single unified instruction/data memory port of the RV32I
// pipeline. Each slot serves the latched data request first (older
// instruction), then the latched fetch, and stalls the pipe until both finish.
module mem_port_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input logic                  clk,
    input logic                  rst,
    mem_port_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;

    logic              pend_d;
    logic              pend_f;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [ADDR_W-1:0] f_addr;

    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              in_access;
    logic              timeout;
    logic              step;
    logic              any_req;

    // Access progress: an access ends on ready, or is abandoned once it has
    // already waited MAX_WAIT cycles and ready is still low.
    always_comb begin
        any_req   = bus.if_req | bus.dm_req;
        in_access = (state == DATA) || (state == FETCH);
        timeout   = in_access && !bus.mem_ready && (wait_cnt == CNT_W'(MAX_WAIT));
        step      = in_access && (bus.mem_ready || timeout);
    end

    // Slot sequencing: data before fetch, one DONE cycle to release the pipe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.dm_req)      state_next = DATA;
                else if (bus.if_req) state_next = FETCH;
            end
            DATA:    if (step) state_next = pend_f ? FETCH : DONE;
            FETCH:   if (step) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the requests seen at slot start; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_d  <= 1'b0;
            pend_f  <= 1'b0;
            d_we    <= 1'b0;
            d_be    <= 4'b0000;
            d_addr  <= '0;
            d_wdata <= '0;
            f_addr  <= '0;
        end else if (state == IDLE && any_req) begin
            pend_d  <= bus.dm_req;
            pend_f  <= bus.if_req;
            d_we    <= bus.dm_we;
            d_be    <= bus.dm_be;
            d_addr  <= bus.dm_addr;
            d_wdata <= bus.dm_wdata;
            f_addr  <= bus.if_addr;
        end else if (state == DONE) begin
            pend_d  <= 1'b0;
            pend_f  <= 1'b0;
        end
    end

    // Wait-state counter, restarted whenever a new access begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (!in_access || step) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // Read-data registers; a timed-out access leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (state == DATA && bus.mem_ready && !d_we) dm_rdata_q <= bus.mem_rdata;
            if (state == FETCH && bus.mem_ready)         if_rdata_q <= bus.mem_rdata;
        end
    end

    // Memory port and pipeline outputs decoded from the current state, so an
    // asynchronous reset drops mem_req and the valid pulses immediately.
    always_comb begin
        bus.mem_req    = in_access;
        bus.mem_we     = 1'b0;
        bus.mem_be     = 4'b0000;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.pipe_stall = 1'b0;
        case (state)
            IDLE: bus.pipe_stall = !rst && any_req;
            DATA: begin
                bus.mem_we     = d_we;
                bus.mem_be     = d_we ? d_be : 4'b0000;
                bus.mem_addr   = d_addr;
                bus.mem_wdata  = d_wdata;
                bus.pipe_stall = !rst;
            end
            FETCH: begin
                bus.mem_addr   = f_addr;
                bus.pipe_stall = !rst;
            end
            default: bus.pipe_stall = 1'b0;
        endcase
        bus.if_valid = (state == DONE) && pend_f;
        bus.dm_valid = (state == DONE) && pend_d;
        bus.mem_err  = timeout;
        bus.if_rdata = if_rdata_q;
        bus.dm_rdata = dm_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-queue
// model of the memory slot.
module tb_mem_port_sequencer;

    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_sequencer #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A slot is a list of memory accesses still owed; when the list empties the
    // next cycle is the release cycle carrying the valid pulses.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          is_data;
    } acc_t;

    acc_t        q[$];
    int          waited;
    bit          done_pend;
    bit          exp_ifv;
    bit          exp_dmv;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            waited     = 0;
            done_pend  = 0;
            exp_ifv    = 0;
            exp_dmv    = 0;
            m_if_rdata = 0;
            m_dm_rdata = 0;
        end else if (q.size() > 0) begin
            if (bus.mem_ready) begin
                if (!q[0].is_data)    m_if_rdata = bus.mem_rdata;
                else if (!q[0].we)    m_dm_rdata = bus.mem_rdata;
                void'(q.pop_front());
                waited = 0;
            end else if (waited == MW) begin
                void'(q.pop_front());
                waited = 0;
            end else begin
                waited++;
            end
            if (q.size() == 0) done_pend = 1;
        end else if (done_pend) begin
            done_pend = 0;
        end else if (bus.if_req || bus.dm_req) begin
            acc_t a;
            exp_dmv = bus.dm_req;
            exp_ifv = bus.if_req;
            if (bus.dm_req) begin
                a.addr = bus.dm_addr; a.we = bus.dm_we; a.be = bus.dm_be;
                a.wdata = bus.dm_wdata; a.is_data = 1;
                q.push_back(a);
            end
            if (bus.if_req) begin
                a.addr = bus.if_addr; a.we = 0; a.be = 0; a.wdata = 0; a.is_data = 0;
                q.push_back(a);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        e_req, e_we, e_stall, e_err, e_ifv, e_dmv;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        e_req = 0; e_we = 0; e_stall = 0; e_err = 0; e_ifv = 0; e_dmv = 0;
        e_be = 0; e_addr = 0; e_wdata = 0;
        if (q.size() > 0) begin
            e_req   = 1;
            e_addr  = q[0].addr;
            e_we    = q[0].we;
            e_be    = q[0].we ? q[0].be : 4'b0000;
            e_wdata = q[0].wdata;
            e_stall = !rst;
            e_err   = !bus.mem_ready && (waited == MW);
        end else if (done_pend) begin
            e_ifv = exp_ifv;
            e_dmv = exp_dmv;
        end else begin
            e_stall = !rst && (bus.if_req || bus.dm_req);
        end
        check("mem_req",    bus.mem_req,    e_req);
        check("mem_we",     bus.mem_we,     e_we);
        check("mem_be",     bus.mem_be,     e_be);
        check("mem_addr",   bus.mem_addr,   e_addr);
        check("mem_wdata",  bus.mem_wdata,  e_wdata);
        check("pipe_stall", bus.pipe_stall, e_stall);
        check("mem_err",    bus.mem_err,    e_err);
        check("if_valid",   bus.if_valid,   e_ifv);
        check("dm_valid",   bus.dm_valid,   e_dmv);
        check("if_rdata",   bus.if_rdata,   m_if_rdata);
        check("dm_rdata",   bus.dm_rdata,   m_dm_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.if_req = 0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0;
        bus.mem_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        bus.if_req = 1; bus.if_addr = 32'h40; bus.dm_req = 1; bus.dm_we = 1;
        bus.dm_be = 4'hF; bus.dm_addr = 32'h80; bus.dm_wdata = 32'h55;
        bus.mem_rdata = 32'h1111_1111; bus.mem_ready = 1;

        // Reset held two cycles with requests active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mem_req", bus.mem_req, 0);
            check("rst_stall",   bus.pipe_stall, 0);
            check("rst_if_valid", bus.if_valid, 0);
            check("rst_dm_rdata", bus.dm_rdata, 0);
        end
        rst = 0;
        quiet();
        tick();
        @(negedge clk);
        check("idle_stall", bus.pipe_stall, 0);

        // Fetch only, zero wait.
        tick();
        bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
        @(negedge clk); check("fo_stall_c1", bus.pipe_stall, 1);
        tick();
        @(negedge clk); check("fo_addr_c2", bus.mem_addr, 32'h100); check("fo_stall_c2", bus.pipe_stall, 1);
        tick(); bus.if_req = 0;
        @(negedge clk);
        check("fo_if_valid", bus.if_valid, 1);
        check("fo_if_rdata", bus.if_rdata, 32'h0050_0093);
        check("fo_stall_c3", bus.pipe_stall, 0);

        // Load + fetch in one slot.
        tick();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h2000;
        bus.if_req = 1; bus.if_addr = 32'h104; bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tick();
        @(negedge clk); check("lf_addr_d", bus.mem_addr, 32'h2000); check("lf_be_load", bus.mem_be, 0);
        tick(); bus.mem_rdata = 32'h0000_0013;
        @(negedge clk); check("lf_addr_f", bus.mem_addr, 32'h104);
        tick(); bus.dm_req = 0; bus.if_req = 0;
        @(negedge clk);
        check("lf_dm_valid", bus.dm_valid, 1);
        check("lf_if_valid", bus.if_valid, 1);
        check("lf_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        check("lf_if_rdata", bus.if_rdata, 32'h0000_0013);
        check("model_pin_dm", m_dm_rdata, 32'hDEAD_BEEF);

        // Store with two wait states.
        tick();
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'b0011; bus.dm_wdata = 32'h1234;
        bus.dm_addr = 32'h3000; bus.mem_ready = 0; bus.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) bus.mem_ready = 1;
            @(negedge clk);
            check("st_we",    bus.mem_we, 1);
            check("st_be",    bus.mem_be, 4'b0011);
            check("st_wdata", bus.mem_wdata, 32'h1234);
        end
        tick(); bus.dm_req = 0; bus.mem_ready = 0;
        @(negedge clk);
        check("st_dm_valid", bus.dm_valid, 1);
        check("st_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);

        // Fetch timeout with ready held low.
        tick();
        bus.dm_we = 0; bus.if_req = 1; bus.if_addr = 32'h200; bus.mem_ready = 0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        for (int i = 0; i < MW; i++) begin
            tick();
            @(negedge clk);
            check("to_no_err", bus.mem_err, 0);
            check("to_req", bus.mem_req, 1);
        end
        tick();
        @(negedge clk); check("to_err", bus.mem_err, 1);
        tick(); bus.if_req = 0;
        @(negedge clk);
        check("to_if_valid", bus.if_valid, 1);
        check("to_if_rdata", bus.if_rdata, 32'h0000_0013);
        check("to_err_done", bus.mem_err, 0);
        check("model_pin_if", m_if_rdata, 32'h0000_0013);
        tick();
        @(negedge clk); check("to_idle_req", bus.mem_req, 0);

        // Asynchronous reset on the second wait cycle of a load.
        tick();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h4000; bus.mem_ready = 0;
        @(negedge clk);
        tick();
        @(negedge clk); check("ra_req_before", bus.mem_req, 1);
        tick();
        #2 rst = 1;
        #1;
        check("ra_req_async", bus.mem_req, 0);
        check("ra_dm_valid", bus.dm_valid, 0);
        bus.dm_req = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("ra_err", bus.mem_err, 0);
        check("ra_dm_valid2", bus.dm_valid, 0);
        rst = 0;
        tick();
        bus.dm_req = 1; bus.dm_addr = 32'h5000; bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        tick();
        @(negedge clk); check("ra_next_addr", bus.mem_addr, 32'h5000);
        tick(); bus.dm_req = 0;
        @(negedge clk);
        check("ra_next_valid", bus.dm_valid, 1);
        check("ra_next_rdata", bus.dm_rdata, 32'hCAFE_F00D);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 800; c++) begin
            tick();
            bus.if_req    = ($urandom_range(0, 9) < 4);
            bus.dm_req    = ($urandom_range(0, 9) < 4);
            bus.dm_we     = $urandom_range(0, 1);
            bus.dm_be     = 4'($urandom_range(0, 15));
            bus.if_addr   = $urandom;
            bus.dm_addr   = $urandom;
            bus.dm_wdata  = $urandom;
            bus.mem_rdata = $urandom;
            bus.mem_ready = ((c / 100) % 2 == 1) ? ($urandom_range(0, 9) < 3)
                                                 : ($urandom_range(0, 9) < 7);
        end

        quiet();
        for (int c = 0; c < 20; c++) tick();
        @(negedge clk);
        check("drain_idle", bus.mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
